// File: rtl/tq_ram_sp_clr.sv
// Single-port RAM with per-lane write mask and a sequential clear engine.
// Each mask lane is its own storage slice; the top owns the clear FSM and access decode.

module tq_ram_sp_clr_lane #(
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LANE_WIDTH-1:0] wdata,
  output logic [LANE_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage has no reset; it is only zeroed by the clear sequence.
  logic [LANE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end
endmodule

module tq_ram_sp_clr #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int LANE_WIDTH = 8,
  parameter int AUTO_CLR   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cen_i,
  input  logic                             wen_i,
  input  logic [WORD_WIDTH/LANE_WIDTH-1:0] mask_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [WORD_WIDTH-1:0]            data_i,
  input  logic                             clr_i,
  output logic [WORD_WIDTH-1:0]            data_o,
  output logic                             busy_o
);
  localparam int NLANE = WORD_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((1 << ADDR_WIDTH) - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    init_pend;

  // init_pend makes the first edge after reset behave like a clr_i pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_o    <= 1'b0;
      init_pend <= (AUTO_CLR != 0);
    end else begin
      case (state)
        IDLE: begin
          if (clr_i || init_pend) begin
            state     <= CLEAR;
            cnt       <= '0;
            busy_o    <= 1'b1;
            init_pend <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                  clearing;
  logic                  acc, rd_en, wr_en;
  logic [NLANE-1:0]      lane_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;

  assign clearing  = (state == CLEAR);
  assign acc       = ~cen_i & ~clearing;
  assign rd_en     = acc & wen_i;
  assign wr_en     = acc & ~wen_i;
  assign lane_we   = clearing ? {NLANE{1'b1}} : ({NLANE{wr_en}} & ~mask_i);
  assign mem_addr  = clearing ? cnt : addr_i;
  assign mem_wdata = clearing ? '0 : data_i;

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    tq_ram_sp_clr_lane #(
      .LANE_WIDTH(LANE_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (lane_we[k]),
      .rd_en(rd_en),
      .addr (mem_addr),
      .wdata(mem_wdata[k*LANE_WIDTH +: LANE_WIDTH]),
      .rdata(data_o[k*LANE_WIDTH +: LANE_WIDTH])
    );
  end
endmodule

// File: doc/tq_ram_sp_clr.md
TQ_RAM_SP_CLR -- requirements
Module: tq_ram_sp_clr

Interface
REQ-001 Parameter WORD_WIDTH, default 16, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the address width; depth DEPTH = 2^ADDR_WIDTH.
REQ-003 Parameter LANE_WIDTH, default 8, SHALL set the write-mask granularity; NLANE = WORD_WIDTH/LANE_WIDTH, WORD_WIDTH SHALL be an integer multiple of LANE_WIDTH.
REQ-004 Parameter AUTO_CLR, default 1, SHALL enable (1) or disable (0) automatic clear after reset.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cen_i  input  1  chip enable, low active.
REQ-008 wen_i  input  1  write enable, low active; qualified by cen_i=0.
REQ-009 mask_i  input  NLANE  per-lane write mask, low active (0 = lane written).
REQ-010 addr_i  input  ADDR_WIDTH  access address.
REQ-011 data_i  input  WORD_WIDTH  write data.
REQ-012 clr_i  input  1  single-cycle clear request, high active.
REQ-013 data_o  output  WORD_WIDTH  registered read data.
REQ-014 busy_o  output  1  high while clear sequence runs; user accesses ignored.

Function
REQ-015 FSM states SHALL be IDLE and CLEAR only.
REQ-016 Read: cen_i=0, wen_i=1, busy_o=0 at edge N -> data_o = mem[addr_i] after edge N (1-cycle latency).
REQ-017 data_o SHALL hold its last value on any cycle without an accepted read, including writes and CLEAR cycles.
REQ-018 Write: cen_i=0, wen_i=0, busy_o=0 -> for each lane k with mask_i[k]=0, mem[addr_i] lane k <= data_i lane k; masked lanes unchanged.
REQ-019 Write with mask_i all ones SHALL leave memory unchanged and SHALL NOT update data_o.
REQ-020 Read and write to the same address in consecutive cycles: the read SHALL return the newly written data (write-then-read, no bypass needed within a cycle since single port).
REQ-021 cen_i=1 SHALL ignore wen_i, mask_i, addr_i, data_i.
REQ-022 IDLE -> CLEAR when clr_i=1; clear counter loads 0; busy_o=1 from the next cycle.
REQ-023 In CLEAR, one entry per cycle: mem[cnt] <= 0 all lanes, cnt increments; after writing DEPTH-1 -> IDLE; busy_o=0 the cycle after the last clear write; total busy duration = DEPTH cycles.
REQ-024 clr_i while busy_o=1 SHALL be ignored (no restart, no extension).
REQ-025 User cen_i=0 accesses during CLEAR SHALL be discarded without effect on memory or data_o; the requester is responsible for checking busy_o.
REQ-026 clr_i and a user access in the same IDLE cycle: the access SHALL complete normally, clear starts next cycle and overwrites it.
REQ-027 Clear counter SHALL be ADDR_WIDTH bits; termination SHALL be detected at cnt = DEPTH-1, never by wrap.
REQ-028 Memory array SHALL not be reset directly; only via the clear sequence.

Reset
REQ-029 rst_n=0 SHALL force data_o=0, cnt=0, busy_o=0 asynchronously.
REQ-030 On rst_n release with AUTO_CLR=1, FSM SHALL enter CLEAR on the first edge (busy_o=1 after it); with AUTO_CLR=0 it SHALL enter IDLE.
REQ-031 Reset asserted during CLEAR SHALL abort; with AUTO_CLR=1 the clear restarts from address 0 after release.

Verification
REQ-032 Defaults, AUTO_CLR=1: release reset -> busy_o high exactly 32 cycles; then reading addresses 0..31 returns 16'h0000.
REQ-033 Write 16'hA5C3 to addr 7 with mask_i=2'b10, after prior 16'hFFFF -> read addr 7 returns 16'hFFC3 one cycle after the read edge.
REQ-034 Write addr 3 = 16'h1234 then read addr 3 next cycle -> data_o=16'h1234; following idle cycles data_o stays 16'h1234.
REQ-035 clr_i pulse, then clr_i again at busy cycle 10 -> busy_o drops after 32 total cycles; all entries 0.
REQ-036 Write addr 5 = 16'hBEEF during busy -> after clear, addr 5 reads 16'h0000; data_o unchanged during busy.
REQ-037 Assert rst_n=0 at clear cycle 12 -> data_o=0, busy_o=0 immediately; after release, full 32-cycle clear repeats.
